fft_frame_feeder: RTL and testbench
===================================

Name: fft_frame_feeder

Overview:
Multi-channel, parametrised framer between per-channel audio sample FIFOs (show-ahead, fft_clk read side) and the FFT sink (Avalon-ST style sop/eop/valid/ready).
- Waits until a channel's FIFO holds a full frame.
- Grants channels round-robin and streams exactly FRAME_LEN samples with correct backpressure.
- Tags each frame with its channel number so downstream equalizer/CPU logic can demultiplex.

Parameters:
DATA_W, 16, sample width
FRAME_LEN, 8192, samples per FFT frame (>=2)
CNT_W, 16, FIFO used-word count width (must represent FRAME_LEN)
N_CHAN, 2, number of input FIFOs/channels (>=1)
CH_W, max(1,$clog2(N_CHAN)), channel tag width (derived)

Ports:
fft_clk  in  1  sole clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  permit new frames to start
fifo_cnt  in  N_CHAN*CNT_W  per-channel rdusedw; channel c at [c*CNT_W +: CNT_W]
fifo_q  in  N_CHAN*DATA_W  per-channel show-ahead head word
fifo_rdreq  out  N_CHAN  per-channel pop strobe
src_data  out  DATA_W  sample to FFT sink_real
src_valid  out  1  beat valid
src_sop  out  1  first beat of frame
src_eop  out  1  last beat of frame
src_chan  out  CH_W  channel of current frame
src_ready  in  1  FFT sink_ready
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after eop beat accepted
frames_sent  out  32  stats (optional feature)
stall_cycles  out  32  stats (optional feature)

Behaviour:
- Reset (async assert, sync-free release): state IDLE, all outputs 0, beat_cnt 0, last_chan N_CHAN-1 (ch0 wins first), counters 0. FIFO contents untouched.
- States: IDLE, STREAM.
- IDLE:
  - Channel c is eligible iff fifo_cnt[c] >= FRAME_LEN.
  - If enable and any channel eligible: cur <= first eligible after last_chan (wrapping), src_chan <= cur, beat_cnt <= 0, busy <= 1, state <= STREAM.
  - Otherwise stay in IDLE.
- STREAM:
  - ld = (!src_valid || src_ready) && beat_cnt < FRAME_LEN.
  - fifo_rdreq[cur] = ld, combinational, same cycle. Exactly FRAME_LEN pops per frame. Never pop any other channel.
  - On ld: src_data <= fifo_q[cur]; src_valid <= 1; src_sop <= (beat_cnt==0); src_eop <= (beat_cnt==FRAME_LEN-1); beat_cnt++.
  - !ld && src_ready: src_valid <= 0.
  - While src_valid && !src_ready: data, sop, eop and chan held stable.
- Frame end: on accept of the eop beat (src_valid && src_ready && src_eop):
  - Next cycle: src_valid 0, frame_done 1 for one cycle, busy 0, last_chan <= cur, state IDLE.
  - Minimum one idle cycle between frames.
- Latency: eligibility seen in IDLE at cycle t -> first beat valid at t+2 (grant at t+1, load at t+1 edge).
- Full-rate throughput with src_ready high: FRAME_LEN consecutive valid beats.
- enable deasserted mid-frame: the current frame completes; it only blocks new grants.
- fifo_cnt of the active channel is not re-checked mid-frame. Availability was guaranteed at grant.
- N_CHAN=1: src_chan is constant 0 and arbitration degenerates.
- Reset mid-frame: immediate abort, no eop emitted. After release, the next frame starts with sop; the partial frame's leftover samples stay in the FIFO.

Optional Feature:
Macro FFT_FEED_STATS_EN.
- Defined:
  - frames_sent increments on each frame_done.
  - stall_cycles increments each cycle with src_valid && !src_ready.
  - Both saturate at 32'hFFFF_FFFF and clear only on reset.
- Undefined: both ports are driven constant 0 and no counter logic is synthesised.

Decomposition:
- Package fft_feed_pkg holds:
  - state enum (IDLE, STREAM)
  - default DATA_W, FRAME_LEN and CNT_W constants
  - a function computing CH_W
- One sub-module, fft_rr_arbiter (parametrised N_CHAN):
  - inputs: eligible vector and last_chan
  - outputs: grant index and any_grant
  - purely combinational

Test Plan:
1. N_CHAN=1, FRAME_LEN=8, fifo_cnt=8, src_ready=1 -> 8 consecutive beats equal to FIFO words in order, sop on beat 0, eop on beat 7, 8 rdreq pulses, frame_done 1 cycle after beat 7, busy then 0.
2. Same setup, src_ready pattern 1,0,0,1,0,1... -> src_data held during stalls, no extra rdreq, exactly 8 pops and 8 accepted beats; with stats enabled, stall_cycles equals the number of stalled valid cycles.
3. N_CHAN=2, both fifo_cnt>=8 continuously -> frames granted ch0, ch1, ch0 with src_chan 0, 1, 0; only the matching fifo_rdreq bit pulses; frames_sent=3.
4. fifo_cnt=7 -> no valid for 20 cycles. Raise to 8 at cycle t -> first src_valid at t+2. With enable=0 -> no start.
5. reset_n asserted at beat 3 of a frame -> all outputs 0 asynchronously. After release with fifo_cnt>=8 -> new frame begins with src_sop=1 and 8 full beats.
6. enable dropped at beat 2 -> frame runs to eop; no further frame starts until enable=1.

Source files
------------

// File: rtl/fft_frame_feeder_pkg.sv
// ============================================================================
//  Module      : fft_feed_pkg
//  Description : Shared types, default sizes and the channel-tag width helper
//                for the FFT frame feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_feed_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_FRAME_LEN = 8192;
  localparam int DEF_CNT_W     = 16;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } feed_state_e;

  // A single channel still needs a one-bit tag so the port never has zero width.
  function automatic int calc_ch_w(input int n_chan);
    return (n_chan > 1) ? $clog2(n_chan) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_frame_feeder_if.sv
// ============================================================================
//  Module      : fft_frame_feeder_if
//  Description : Avalon-ST style source bus between the frame feeder and the
//                FFT sink (data/valid/sop/eop/chan forward, ready backward).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fft_frame_feeder_if
  import fft_feed_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CH_W   = 1
);

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              sop;
  logic              eop;
  logic [CH_W-1:0]   chan;
  logic              ready;

  modport master (output data, valid, sop, eop, chan, input ready);
  modport slave  (input data, valid, sop, eop, chan, output ready);

endinterface

`default_nettype wire

// File: rtl/fft_rr_arbiter.sv
// ============================================================================
//  Module      : fft_rr_arbiter
//  Description : Combinational round-robin pick of the first eligible channel
//                strictly after the previously served one, wrapping around.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_rr_arbiter
  import fft_feed_pkg::*;
#(
  parameter int N_CHAN = 2,
  parameter int CH_W   = calc_ch_w(N_CHAN)
) (
  input  logic [N_CHAN-1:0] eligible,
  input  logic [CH_W-1:0]   last_chan,
  output logic [CH_W-1:0]   grant,
  output logic              any_grant
);

  // Scan outward from last_chan+1; last_chan itself is visited last.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    any_grant = 1'b0;
    for (int k = 1; k <= N_CHAN; k++) begin
      idx = (int'(last_chan) + k) % N_CHAN;
      if (!any_grant && eligible[idx]) begin
        any_grant = 1'b1;
        grant     = CH_W'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fft_frame_feeder.sv
// ============================================================================
//  Module      : fft_frame_feeder
//  Description : Round-robin framer from per-channel show-ahead sample FIFOs
//                into an FFT sink. A channel is granted only once it holds a
//                whole frame; exactly FRAME_LEN samples are then streamed with
//                backpressure and tagged with the channel number.
//                Optional statistics counters: define FFT_FEED_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_frame_feeder
  import fft_feed_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int N_CHAN    = 2,
  parameter int CH_W      = calc_ch_w(N_CHAN)
) (
  input  logic                     fft_clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [N_CHAN*CNT_W-1:0]  fifo_cnt,
  input  logic [N_CHAN*DATA_W-1:0] fifo_q,
  output logic [N_CHAN-1:0]        fifo_rdreq,
  fft_frame_feeder_if.master       src,
  output logic                     busy,
  output logic                     frame_done,
  output logic [31:0]              frames_sent,
  output logic [31:0]              stall_cycles
);

  localparam int                c_BEAT_W      = $clog2(FRAME_LEN + 1);
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(FRAME_LEN - 1);
  localparam logic [c_BEAT_W-1:0] c_FULL      = c_BEAT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  c_FRAME_CNT   = CNT_W'(FRAME_LEN);
  localparam logic [CH_W-1:0]   c_LAST_CH_RST = CH_W'(N_CHAN - 1);

  feed_state_e          r_state, w_state_nxt;
  logic [CH_W-1:0]      r_cur, r_last_chan;
  logic [c_BEAT_W-1:0]  r_beat_cnt;
  logic [DATA_W-1:0]    r_data;
  logic                 r_valid, r_sop, r_eop, r_busy, r_frame_done;
  logic [CH_W-1:0]      r_chan;

  logic [N_CHAN-1:0]    w_eligible;
  logic [CH_W-1:0]      w_grant;
  logic                 w_any;
  logic                 w_start, w_ld, w_eop_acc;
  logic [DATA_W-1:0]    w_head;

  generate
    for (genvar c = 0; c < N_CHAN; c++) begin : g_elig
      assign w_eligible[c] = (fifo_cnt[c*CNT_W +: CNT_W] >= c_FRAME_CNT);
    end
  endgenerate

  fft_rr_arbiter #(.N_CHAN(N_CHAN), .CH_W(CH_W)) u_arb (
    .eligible  (w_eligible),
    .last_chan (r_last_chan),
    .grant     (w_grant),
    .any_grant (w_any)
  );

  assign w_head = fifo_q[int'(r_cur)*DATA_W +: DATA_W];

  // State register.
  always_ff @(posedge fft_clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, grant strobe and the same-cycle pop of the active FIFO.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_ld        = 1'b0;
    w_eop_acc   = 1'b0;
    fifo_rdreq  = '0;
    case (r_state)
      ST_IDLE: begin
        if (enable && w_any) begin
          w_start     = 1'b1;
          w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        w_ld              = (!r_valid || src.ready) && (r_beat_cnt < c_FULL);
        fifo_rdreq[r_cur] = w_ld;
        w_eop_acc         = r_valid && src.ready && r_eop;
        if (w_eop_acc) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output beat register: load on pop, drop valid once the beat is taken.
  always_ff @(posedge fft_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur        <= '0;
      r_last_chan  <= c_LAST_CH_RST;
      r_beat_cnt   <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
      r_chan       <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_start) begin
        r_cur      <= w_grant;
        r_chan     <= w_grant;
        r_beat_cnt <= '0;
        r_busy     <= 1'b1;
      end
      if (w_ld) begin
        r_data     <= w_head;
        r_valid    <= 1'b1;
        r_sop      <= (r_beat_cnt == '0);
        r_eop      <= (r_beat_cnt == c_LAST_BEAT);
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end else if (src.ready) begin
        r_valid <= 1'b0;
        r_sop   <= 1'b0;
        r_eop   <= 1'b0;
      end
      if (w_eop_acc) begin
        r_frame_done <= 1'b1;
        r_busy       <= 1'b0;
        r_last_chan  <= r_cur;
      end
    end
  end

  assign src.data   = r_data;
  assign src.valid  = r_valid;
  assign src.sop    = r_sop;
  assign src.eop    = r_eop;
  assign src.chan   = r_chan;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

`ifdef FFT_FEED_STATS_EN
  logic [31:0] r_frames_sent, r_stall_cycles;

  // Saturating frame and stall counters, cleared only by reset.
  always_ff @(posedge fft_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frames_sent  <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (r_frame_done && (r_frames_sent != 32'hFFFF_FFFF))
        r_frames_sent <= r_frames_sent + 32'd1;
      if (r_valid && !src.ready && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign frames_sent  = r_frames_sent;
  assign stall_cycles = r_stall_cycles;
`else
  assign frames_sent  = 32'd0;
  assign stall_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_feeder.sv
// ============================================================================
//  Module      : tb_fft_frame_feeder
//  Description : Self-checking bench for fft_frame_feeder (2 channels, 8-sample
//                frames) with show-ahead FIFO models and a beat scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fft_frame_feeder;
  import fft_feed_pkg::*;

  localparam int DW  = 16;
  localparam int FL  = 8;
  localparam int CW  = 16;
  localparam int NC  = 2;
  localparam int CHW = calc_ch_w(NC);

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic           sop;
    logic           eop;
    logic [DW-1:0]  d;
  } beat_t;

  logic              fft_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable  = 1'b0;
  logic [NC*CW-1:0]  fifo_cnt;
  logic [NC*DW-1:0]  fifo_q;
  logic [NC-1:0]     fifo_rdreq;
  logic              busy, frame_done;
  logic [31:0]       frames_sent, stall_cycles;

  fft_frame_feeder_if #(.DATA_W(DW), .CH_W(CHW)) src_if ();

  fft_frame_feeder #(
    .DATA_W(DW), .FRAME_LEN(FL), .CNT_W(CW), .N_CHAN(NC), .CH_W(CHW)
  ) dut (
    .fft_clk      (fft_clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .fifo_cnt     (fifo_cnt),
    .fifo_q       (fifo_q),
    .fifo_rdreq   (fifo_rdreq),
    .src          (src_if),
    .busy         (busy),
    .frame_done   (frame_done),
    .frames_sent  (frames_sent),
    .stall_cycles (stall_cycles)
  );

  always #5 fft_clk = ~fft_clk;

  logic [DW-1:0] fq0[$], fq1[$], ex0[$], ex1[$];
  beat_t         sb[$];
  logic [DW-1:0] seq0 = 16'h1000, seq1 = 16'h2000;
  logic [NC-1:0] pend = '0;
  logic          eop_prev = 1'b0;
  int checks = 0, failures = 0;
  int cyc = 0, acc_cnt, pop_cnt, vld_cnt, done_cnt, stall_cnt, first_v, last_v;
  int frames_tot = 0, stall_tot = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    logic [DW-1:0] h0, h1;
    h0 = (fq0.size() > 0) ? fq0[0] : '0;
    h1 = (fq1.size() > 0) ? fq1[0] : '0;
    fifo_cnt = {CW'(fq1.size()), CW'(fq0.size())};
    fifo_q   = {h1, h0};
  endtask

  task automatic push(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      if (ch == 0) begin fq0.push_back(seq0); ex0.push_back(seq0); seq0++; end
      else         begin fq1.push_back(seq1); ex1.push_back(seq1); seq1++; end
    end
    refresh();
  endtask

  task automatic expect_frame(input int ch);
    beat_t b;
    for (int i = 0; i < FL; i++) begin
      b.ch  = CHW'(ch);
      b.sop = (i == 0);
      b.eop = (i == FL - 1);
      b.d   = (ch == 0) ? ex0.pop_front() : ex1.pop_front();
      sb.push_back(b);
    end
  endtask

  task automatic clear_cnt();
    acc_cnt = 0; pop_cnt = 0; vld_cnt = 0; done_cnt = 0; stall_cnt = 0; first_v = -1; last_v = -1;
  endtask

  task automatic monitor();
    beat_t got, e;
    cyc++;
    pend = fifo_rdreq;
    if (fifo_rdreq != '0) begin
      pop_cnt++;
      if (sb.size() == 0) chk("rdreq_unexpected", 64'(fifo_rdreq), 64'd0);
      else                chk("rdreq_chan", 64'(fifo_rdreq), 64'(NC'(1) << sb[0].ch));
    end
    if (src_if.valid) begin
      vld_cnt++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (src_if.valid && !src_if.ready) begin stall_cnt++; stall_tot++; end
    if (frame_done || eop_prev) begin
      chk("frame_done", 64'(frame_done), 64'(eop_prev));
      if (frame_done) begin
        chk("busy_at_done", 64'(busy), 64'd0);
        done_cnt++; frames_tot++;
      end
    end
    eop_prev = 1'b0;
    if (src_if.valid && src_if.ready) begin
      acc_cnt++;
      got = {src_if.chan, src_if.sop, src_if.eop, src_if.data};
      if (sb.size() == 0) chk("beat_unexpected", 64'(got), 64'd0);
      else begin
        e = sb.pop_front();
        chk("beat", 64'(got), 64'(e));
      end
      eop_prev = src_if.eop;
    end
  endtask

  task automatic tick();
    @(negedge fft_clk);
    monitor();
    @(posedge fft_clk);
    #1;
    if (pend[0] && fq0.size() > 0) void'(fq0.pop_front());
    if (pend[1] && fq1.size() > 0) void'(fq1.pop_front());
    refresh();
  endtask

  task automatic run_frames(input int n, input int budget, input string tag, input logic [15:0] pat);
    int target, k;
    target = done_cnt + n;
    k = 0;
    while (done_cnt < target && k < budget) begin
      src_if.ready = pat[k % 16];
      tick();
      k++;
    end
    if (done_cnt < target) chk({tag, "_timeout"}, 64'(done_cnt), 64'(target));
  endtask

  task automatic tick_until_acc(input int n, input string tag);
    int k;
    k = 0;
    while (acc_cnt < n && k < 40) begin tick(); k++; end
    chk({tag, "_reach_beat"}, 64'(acc_cnt), 64'(n));
  endtask

  task automatic check_stats(input string tag);
`ifdef FFT_FEED_STATS_EN
    chk({tag, "_frames_sent"}, 64'(frames_sent), 64'(frames_tot));
    chk({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(stall_tot));
`else
    chk({tag, "_frames_sent"}, 64'(frames_sent), 64'd0);
    chk({tag, "_stall_cycles"}, 64'(stall_cycles), 64'd0);
`endif
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({busy, frame_done, src_if.valid, src_if.sop, src_if.eop,
                src_if.chan, src_if.data, fifo_rdreq});
  endfunction

  task automatic reset_now(input string tag);
    reset_n = 1'b0;
    #1;
    chk({tag, "_outputs_zero"}, out_vec(), 64'd0);
    sb.delete();
    eop_prev   = 1'b0;
    frames_tot = 0;
    stall_tot  = 0;
    ex0 = fq0;
    ex1 = fq1;
    repeat (2) tick();
    check_stats({tag, "_rst"});
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    src_if.ready = 1'b0;
    refresh();
    clear_cnt();
    repeat (3) tick();
    chk("reset_state", out_vec(), 64'd0);
    check_stats("reset");
    reset_n = 1'b1;
    tick();

    // Single channel, full-rate frame.
    push(0, FL); expect_frame(0);
    enable = 1'b1; src_if.ready = 1'b1; clear_cnt();
    run_frames(1, 60, "t1", 16'hFFFF);
    chk("t1_accepted", 64'(acc_cnt), 64'(FL));
    chk("t1_pops", 64'(pop_cnt), 64'(FL));
    chk("t1_span", 64'(last_v - first_v + 1), 64'(FL));
    chk("t1_busy_end", 64'(busy), 64'd0);
    check_stats("t1");

    // Backpressure: 1,0,0,1,0,1,1,0,0,1,0,1,0,0,1,1 (LSB first).
    push(0, FL); expect_frame(0); clear_cnt();
    run_frames(1, 100, "t2", 16'b1100_1010_0110_1001);
    src_if.ready = 1'b1;
    chk("t2_accepted", 64'(acc_cnt), 64'(FL));
    chk("t2_pops", 64'(pop_cnt), 64'(FL));
    chk("t2_stalled", 64'(stall_cnt > 0), 64'd1);
    check_stats("t2");

    // Seven words is not a frame; the eighth starts one two cycles later.
    clear_cnt();
    push(0, FL - 1);
    repeat (20) tick();
    chk("t4_no_valid", 64'(vld_cnt), 64'd0);
    chk("t4_idle_busy", 64'(busy), 64'd0);
    push(0, 1); expect_frame(0);
    tick();
    chk("t4_grant_cycle", 64'({busy, src_if.valid}), 64'b10);
    tick();
    chk("t4_first_valid", 64'({src_if.valid, src_if.sop}), 64'b11);
    run_frames(1, 60, "t4", 16'hFFFF);
    chk("t4_accepted", 64'(acc_cnt), 64'(FL));

    // Disabled: a full FIFO must not start a frame.
    enable = 1'b0; push(0, FL); clear_cnt();
    repeat (20) tick();
    chk("t4_disabled_no_valid", 64'(vld_cnt), 64'd0);
    chk("t4_disabled_busy", 64'(busy), 64'd0);

    // Enable dropped at beat 2: frame completes, nothing further starts.
    push(0, FL); expect_frame(0);
    enable = 1'b1; clear_cnt();
    tick_until_acc(2, "t6");
    enable = 1'b0;
    run_frames(1, 60, "t6", 16'hFFFF);
    chk("t6_accepted", 64'(acc_cnt), 64'(FL));
    clear_cnt();
    repeat (20) tick();
    chk("t6_no_restart", 64'(vld_cnt), 64'd0);
    expect_frame(0); enable = 1'b1;
    run_frames(1, 60, "t6b", 16'hFFFF);
    chk("t6b_accepted", 64'(acc_cnt), 64'(FL));
    check_stats("t6");

    // Reset at beat 3: abort, leftover stays, next frame restarts with sop.
    push(0, FL); expect_frame(0); clear_cnt();
    tick_until_acc(3, "t5");
    reset_now("t5");
    sb.delete();
    push(0, FL); expect_frame(0); clear_cnt();
    run_frames(1, 60, "t5", 16'hFFFF);
    chk("t5_accepted", 64'(acc_cnt), 64'(FL));
    chk("t5_pops", 64'(pop_cnt), 64'(FL));

    // Two channels both loaded: ch0, ch1, ch0 after reset.
    enable = 1'b0;
    reset_now("t3");
    push(0, 2 * FL); push(1, FL);
    expect_frame(0); expect_frame(1); expect_frame(0);
    enable = 1'b1; clear_cnt();
    run_frames(3, 200, "t3", 16'hFFFF);
    chk("t3_frames", 64'(done_cnt), 64'd3);
    chk("t3_accepted", 64'(acc_cnt), 64'(3 * FL));
    chk("t3_pops", 64'(pop_cnt), 64'(3 * FL));
    check_stats("t3");

    repeat (5) tick();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
